// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display arbiter: FSM states,
// segment encodings and the requester limit.
package hex_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int MAX_REQ = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp, g, f, e, d, c, b, a}; dp is held off in every entry.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_display_arbiter_seg7_decode.sv
// Hex nibble to active-low 7-segment pattern, with a blank override.
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin time-sharing of six hex digits between NUM_REQ requesters.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [24*NUM_REQ-1:0]  VALUE,
  output logic [NUM_REQ-1:0]     GRANT,
  output logic [7:0]             HEX0,
  output logic [7:0]             HEX1,
  output logic [7:0]             HEX2,
  output logic [7:0]             HEX3,
  output logic [7:0]             HEX4,
  output logic [7:0]             HEX5,
  output logic                   dbg_state_o
);

  localparam int CNT_W  = $clog2(DWELL_CYCLES);
  localparam int LAST_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [LAST_W-1:0] LAST_INIT = LAST_W'(NUM_REQ - 1);

  // Handshake: REQ is a level held by the requester for as long as it wants
  // the display; GRANT is a registered one-hot that stays high for the slot
  // and moves to the next requester on the same edge the old bit falls.
  state_e              state_q, state_d;
  logic [LAST_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [23:0]         value_q, value_d;
  logic [7:0]          hex_q [6];
  logic [7:0]          hex_d [6];
  logic [7:0]          seg_d [6];
  logic [5:0]          blank;

  logic                scan_found;
  logic [LAST_W-1:0]   scan_winner;
  logic [NUM_REQ-1:0]  scan_onehot;
  int                  scan_idx;
  logic                holder_req;
  logic                slot_end;

  // Scan from last+1 around to last itself; the descending loop lets the
  // nearest pending requester overwrite farther ones.
  always_comb begin
    scan_found  = 1'b0;
    scan_winner = '0;
    scan_onehot = '0;
    scan_idx    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = int'(last_q) + i;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if ((REQ & (NUM_REQ'(1) << scan_idx)) != '0) begin
        scan_found  = 1'b1;
        scan_winner = LAST_W'(scan_idx);
        scan_onehot = NUM_REQ'(1) << scan_idx;
      end
    end
  end

  assign holder_req = |(REQ & grant_q);
  assign slot_end   = (cnt_q == CNT_LAST) || !holder_req;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (scan_found) begin
          state_d = SHOW;
          grant_d = scan_onehot;
          last_d  = scan_winner;
          cnt_d   = '0;
          value_d = 24'(VALUE >> (24 * int'(scan_winner)));
        end
      end
      SHOW: begin
        if (slot_end) begin
          if (scan_found) begin
            grant_d = scan_onehot;
            last_d  = scan_winner;
            cnt_d   = '0;
            value_d = 24'(VALUE >> (24 * int'(scan_winner)));
          end else begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      last_q  <= LAST_INIT;
      grant_q <= '0;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  for (genvar k = 0; k < 6; k++) begin : g_digit
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    if (k == 0) begin : g_lsd
      assign blank[k] = 1'b0;
    end else begin : g_upper
      assign blank[k] = (value_q[23:4*k] == '0);
    end
`else
    assign blank[k] = 1'b0;
`endif

    seg7_decode u_dec (
      .nibble_i (value_q[4*k +: 4]),
      .blank_i  (blank[k]),
      .seg_o    (seg_d[k])
    );

    assign hex_d[k] = (state_q == SHOW) ? seg_d[k] : SEG_BLANK;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 6; k++) begin
        hex_q[k] <= SEG_BLANK;
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        hex_q[k] <= hex_d[k];
      end
    end
  end

  assign GRANT       = grant_q;
  assign HEX0        = hex_q[0];
  assign HEX1        = hex_q[1];
  assign HEX2        = hex_q[2];
  assign HEX3        = hex_q[3];
  assign HEX4        = hex_q[4];
  assign HEX5        = hex_q[5];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter (NUM_REQ=2, DWELL_CYCLES=4):
// directed vector table, corner sequences and a randomized model comparison.
module tb_hex_display_arbiter;

  localparam int N  = 2;
  localparam int DW = 4;

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N  = 1'b0;
  logic [N-1:0]     REQ      = '0;
  logic [24*N-1:0]  VALUE    = '0;
  logic [N-1:0]     GRANT;
  logic [7:0]       HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic             dbg_state;
  logic [47:0]      hex_bus;

  int checks   = 0;
  int failures = 0;

  hex_display_arbiter #(
    .NUM_REQ      (N),
    .DWELL_CYCLES (DW)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .REQ         (REQ),
    .VALUE       (VALUE),
    .GRANT       (GRANT),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5),
    .dbg_state_o (dbg_state)
  );

  assign hex_bus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  // ---------------- clock / watchdog ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  string digit_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    string      t;
    int         c;
    s = 8'hFF;
    t = digit_segs[d];
    for (int i = 0; i < t.len(); i++) begin
      c = int'(t[i]) - 97;
      s = s & ~(8'(1) << c);
    end
    return s;
  endfunction

  function automatic logic [47:0] hex_of(input logic [23:0] v);
    logic [47:0] r;
    logic [7:0]  dg;
`ifdef LEADING_ZERO_BLANK_EN
    int top;
    top = 0;
    for (int k = 0; k < 6; k++) if (v[4*k +: 4] != 4'h0) top = k;
`endif
    r = '0;
    for (int k = 0; k < 6; k++) begin
      dg = seg_of(v[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > top) dg = 8'hFF;
`endif
      r[8*k +: 8] = dg;
    end
    return r;
  endfunction

  int          m_owner;
  int          m_age;
  int          m_last;
  logic [23:0] m_val;
  logic [47:0] m_hex;

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = N - 1;
    m_val   = '0;
    m_hex   = {6{8'hFF}};
  endtask

  function automatic bit req_on(input int r);
    return ((REQ >> r) & N'(1)) != '0;
  endfunction

  function automatic int pick();
    int r;
    for (int d = 1; d <= N; d++) begin
      r = (m_last + d) % N;
      if (req_on(r)) return r;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_owner = w;
    m_last  = w;
    m_age   = 0;
    m_val   = VALUE[24*w +: 24];
  endtask

  // One rising edge of the DUT, seen at the spec's level of rules.
  task automatic model_step();
    int          w;
    logic [47:0] nh;
    nh = (m_owner >= 0) ? hex_of(m_val) : {6{8'hFF}};
    if (m_owner < 0) begin
      w = pick();
      if (w >= 0) grant_to(w);
    end else if (m_age == DW - 1 || !req_on(m_owner)) begin
      w = pick();
      if (w >= 0) grant_to(w);
      else m_owner = -1;
    end else begin
      m_age++;
    end
    m_hex = nh;
  endtask

  function automatic logic [N-1:0] exp_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " grant"}, 48'(GRANT), 48'(exp_grant()));
    check({tag, " hex"}, hex_bus, m_hex);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [23:0]  v0;
    logic [23:0]  v1;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_hex0;
  } row_t;

  row_t rows [10];

  initial begin
    logic [47:0] lz_exp;
    bool_wait: begin end

    rows[0] = '{2'b11, 24'h000001, 24'h000010, 2'b01, 8'hFF};
    rows[1] = '{2'b11, 24'h000001, 24'h000010, 2'b01, 8'hF9};
    rows[2] = '{2'b11, 24'h000001, 24'h000010, 2'b01, 8'hF9};
    rows[3] = '{2'b11, 24'h000001, 24'h000010, 2'b01, 8'hF9};
    rows[4] = '{2'b11, 24'h000001, 24'h000010, 2'b10, 8'hF9};
    rows[5] = '{2'b11, 24'h000001, 24'h000010, 2'b10, 8'hC0};
    rows[6] = '{2'b11, 24'h000001, 24'h000010, 2'b10, 8'hC0};
    rows[7] = '{2'b11, 24'h000001, 24'h000010, 2'b10, 8'hC0};
    rows[8] = '{2'b11, 24'h000001, 24'h000010, 2'b01, 8'hC0};
    rows[9] = '{2'b11, 24'h000001, 24'h000010, 2'b01, 8'hF9};

    // Reset held with both requesters asking.
    model_reset();
    REQ   = 2'b11;
    VALUE = {24'h000010, 24'h000001};
    repeat (3) @(negedge CLOCK_50);
    check("reset grant", 48'(GRANT), 48'h0);
    check("reset hex", hex_bus, {6{8'hFF}});
    RESET_N = 1'b1;

    // Alternation table.
    for (int i = 0; i < 10; i++) begin
      REQ   = rows[i].req;
      VALUE = {rows[i].v1, rows[i].v0};
      tick();
      check($sformatf("table%0d grant", i), 48'(GRANT), 48'(rows[i].exp_grant));
      check($sformatf("table%0d hex0", i), 48'(HEX0), 48'(rows[i].exp_hex0));
      if (i == 1) check("first slot digits", hex_bus, hex_of(24'h000001));
      check_model($sformatf("table%0d model", i));
    end

    // Only requester 0; its value changes mid-slot.
    REQ = 2'b01;
    tick();
    VALUE[23:0] = 24'h00ABCD;
    tick();
    check("frozen hex0", 48'(HEX0), 48'h0000_0000_00F9);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("solo%0d grant", i), 48'(GRANT), 48'h1);
      check_model($sformatf("solo%0d", i));
    end
    check("relatched value", hex_bus, hex_of(24'h00ABCD));

    // Requester 1 releases two cycles into its slot.
    REQ = 2'b11;
    for (int i = 0; i < 20 && GRANT != 2'b10; i++) begin
      tick();
      check_model("wait r1");
    end
    check("reached r1 slot", 48'(GRANT), 48'h2);
    tick();
    tick();
    REQ = 2'b01;
    tick();
    check("early release grant", 48'(GRANT), 48'h1);
    check("early release no blank", 48'(HEX0 == 8'hFF), 48'h0);
    check_model("early release");
    tick();
    check_model("after release");

    // Asynchronous reset between edges while requester 0 holds.
    REQ = 2'b11;
    @(posedge CLOCK_50);
    model_step();
    #2 RESET_N = 1'b0;
    #1;
    check("async reset grant", 48'(GRANT), 48'h0);
    check("async reset hex", hex_bus, {6{8'hFF}});
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    tick();
    check("rr restart", 48'(GRANT), 48'h1);
    check_model("rr restart");

    // All-zero value, leading-zero handling.
    REQ   = 2'b01;
    VALUE = {24'h000010, 24'h000000};
    repeat (DW + 2) begin
      tick();
      check_model("zero value");
    end
`ifdef LEADING_ZERO_BLANK_EN
    lz_exp = {40'hFF_FFFF_FFFF, 8'hC0};
`else
    lz_exp = {6{8'hC0}};
`endif
    check("zero value digits", hex_bus, lz_exp);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        RESET_N = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        check_model("rand reset");
      end
      if ($urandom_range(0, 3) == 0) REQ = N'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) VALUE = {24'($urandom), 24'($urandom)};
      if ($urandom_range(0, 9) == 0) VALUE[23:0] = 24'($urandom_range(0, 255));
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
